// File: rtl/decode_stage.sv
// decode_stage: ID-side capture of the fetch register, RV32I field/immediate decode and front-end control.
// Optional load-use stall is built only when DECODE_LOAD_USE_EN is defined.
module decode_stage #(
    parameter int WARMUP_CYCLES = 2,
    parameter int FLUSH_DEPTH   = 2
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic [31:0] FETCH_IR,
    input  logic [31:0] FETCH_PC,
    input  logic [31:0] FETCH_PC_4,
    input  logic        FLUSH,
    input  logic        EX_MEM_READ,
    input  logic [4:0]  EX_RD_ADDR,
    output logic        PC_WRITE,
    output logic        DEC_VALID,
    output logic        DEC_BUBBLE,
    output logic [31:0] DEC_IR,
    output logic [31:0] DEC_PC,
    output logic [31:0] DEC_PC_4,
    output logic [6:0]  DEC_OPCODE,
    output logic [4:0]  DEC_RD_ADDR,
    output logic [4:0]  DEC_RS1_ADDR,
    output logic [4:0]  DEC_RS2_ADDR,
    output logic [31:0] DEC_IMM
);

    localparam logic [1:0] WARM_INIT  = 2'(WARMUP_CYCLES - 1);
    localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_DEPTH - 1);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [1:0] {
        WARMUP = 2'd0,
        RUN    = 2'd1,
        SQUASH = 2'd2,
        STALL  = 2'd3
    } state_t;

    state_t     state;
    logic [1:0] cnt;
    logic       haz;
    logic       stall_req;

    function automatic logic [31:0] imm_gen(input logic [31:0] ir);
        case (ir[6:0])
            OPC_OP_IMM, OPC_LOAD, OPC_JALR:
                imm_gen = {{20{ir[31]}}, ir[31:20]};
            OPC_STORE:
                imm_gen = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            OPC_BRANCH:
                imm_gen = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm_gen = {ir[31:12], 12'b0};
            OPC_JAL:
                imm_gen = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            default:
                imm_gen = 32'd0;
        endcase
    endfunction

    assign DEC_OPCODE   = DEC_IR[6:0];
    assign DEC_RD_ADDR  = DEC_IR[11:7];
    assign DEC_RS1_ADDR = DEC_IR[19:15];
    assign DEC_RS2_ADDR = DEC_IR[24:20];
    assign DEC_IMM      = imm_gen(DEC_IR);

`ifdef DECODE_LOAD_USE_EN
    logic rs1_used;
    logic rs2_used;

    always_comb begin
        rs1_used = !((DEC_OPCODE == OPC_LUI) || (DEC_OPCODE == OPC_AUIPC) ||
                     (DEC_OPCODE == OPC_JAL));
        rs2_used = (DEC_OPCODE == OPC_OP) || (DEC_OPCODE == OPC_STORE) ||
                   (DEC_OPCODE == OPC_BRANCH);
        haz = (state == RUN) && DEC_VALID && EX_MEM_READ && (EX_RD_ADDR != 5'd0) &&
              ((rs1_used && (DEC_RS1_ADDR == EX_RD_ADDR)) ||
               (rs2_used && (DEC_RS2_ADDR == EX_RD_ADDR)));
    end
`else
    logic unused_ex;
    assign unused_ex = ^{EX_MEM_READ, EX_RD_ADDR};
    assign haz       = 1'b0;
`endif

    // A redirect overrides the stall: the stalled instruction is on the wrong path anyway.
    assign stall_req  = haz && !FLUSH;
    assign PC_WRITE   = !stall_req;
    assign DEC_BUBBLE = stall_req;

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state     <= WARMUP;
            cnt       <= WARM_INIT;
            DEC_VALID <= 1'b0;
            DEC_IR    <= 32'd0;
            DEC_PC    <= 32'd0;
            DEC_PC_4  <= 32'd0;
        end else begin
            if (!stall_req) begin
                DEC_IR   <= FETCH_IR;
                DEC_PC   <= FETCH_PC;
                DEC_PC_4 <= FETCH_PC_4;
            end
            if (FLUSH && (state != WARMUP)) begin
                state     <= SQUASH;
                cnt       <= FLUSH_INIT;
                DEC_VALID <= 1'b0;
            end else begin
                case (state)
                    WARMUP, SQUASH: begin
                        DEC_VALID <= 1'b0;
                        if (cnt == 2'd0) state <= RUN;
                        else             cnt   <= cnt - 2'd1;
                    end
                    RUN: begin
                        DEC_VALID <= 1'b1;
                        if (stall_req) state <= STALL;
                    end
                    STALL: begin
                        DEC_VALID <= 1'b1;
                        state     <= RUN;
                    end
                    default: state <= WARMUP;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: scoreboard of captured fetch words plus control checks.
module tb_decode_stage;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b0;
    logic [31:0] FETCH_IR = 32'd0;
    logic [31:0] FETCH_PC = 32'd0;
    logic [31:0] FETCH_PC_4 = 32'd0;
    logic        FLUSH = 1'b0;
    logic        EX_MEM_READ = 1'b0;
    logic [4:0]  EX_RD_ADDR = 5'd0;
    logic        PC_WRITE;
    logic        DEC_VALID;
    logic        DEC_BUBBLE;
    logic [31:0] DEC_IR;
    logic [31:0] DEC_PC;
    logic [31:0] DEC_PC_4;
    logic [6:0]  DEC_OPCODE;
    logic [4:0]  DEC_RD_ADDR;
    logic [4:0]  DEC_RS1_ADDR;
    logic [4:0]  DEC_RS2_ADDR;
    logic [31:0] DEC_IMM;

    localparam logic [31:0] ADDI5  = 32'h00500093;  // addi x1,x0,5
    localparam logic [31:0] ADDIM1 = 32'hFFF00093;  // addi x1,x0,-1
    localparam logic [31:0] BEQM4  = 32'hFE000EE3;  // beq x0,x0,-4
    localparam logic [31:0] ADD312 = 32'h002081B3;  // add x3,x1,x2
    localparam logic [31:0] LUI28  = 32'h000282B7;  // lui x5,0x28 (rs1 field = 5)
    localparam logic [31:0] SW8    = 32'h0020A423;  // sw x2,8(x1)
    localparam logic [31:0] SWM4   = 32'hFE20AE23;  // sw x2,-4(x1)
    localparam logic [31:0] JAL8   = 32'h008000EF;  // jal x1,8
    localparam logic [31:0] JALM8  = 32'hFF9FF06F;  // jal x0,-8
    localparam logic [31:0] FENCEX = 32'hFFF0000F;  // non-immediate opcode
    localparam logic [31:0] JUNK   = 32'hDEADBEEF;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] imm;
    } rec_t;

    rec_t        exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] pc = 32'h0000_0100;

    decode_stage dut (
        .CLOCK       (CLOCK),
        .RESET       (RESET),
        .FETCH_IR    (FETCH_IR),
        .FETCH_PC    (FETCH_PC),
        .FETCH_PC_4  (FETCH_PC_4),
        .FLUSH       (FLUSH),
        .EX_MEM_READ (EX_MEM_READ),
        .EX_RD_ADDR  (EX_RD_ADDR),
        .PC_WRITE    (PC_WRITE),
        .DEC_VALID   (DEC_VALID),
        .DEC_BUBBLE  (DEC_BUBBLE),
        .DEC_IR      (DEC_IR),
        .DEC_PC      (DEC_PC),
        .DEC_PC_4    (DEC_PC_4),
        .DEC_OPCODE  (DEC_OPCODE),
        .DEC_RD_ADDR (DEC_RD_ADDR),
        .DEC_RS1_ADDR(DEC_RS1_ADDR),
        .DEC_RS2_ADDR(DEC_RS2_ADDR),
        .DEC_IMM     (DEC_IMM)
    );

    initial forever #5 CLOCK = ~CLOCK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Present one fetch word, clock it in, and check the decode side one posedge later.
    task automatic cyc(input logic [31:0] ir, input logic [31:0] imm, input bit keep,
                       input bit exp_v, input string tag);
        rec_t r;
        FETCH_IR   = ir;
        FETCH_PC   = pc;
        FETCH_PC_4 = pc + 32'd4;
        if (keep) begin
            r.ir  = ir;
            r.pc  = pc;
            r.pc4 = pc + 32'd4;
            r.imm = imm;
            exp_q.push_back(r);
        end
        pc = pc + 32'd4;
        @(posedge CLOCK);
        #1;
        chk({tag, "_valid"}, {31'd0, DEC_VALID}, {31'd0, exp_v});
        if (DEC_VALID) begin
            chk({tag, "_sb_nonempty"}, {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                r = exp_q.pop_front();
                chk({tag, "_ir"},  DEC_IR,   r.ir);
                chk({tag, "_pc"},  DEC_PC,   r.pc);
                chk({tag, "_pc4"}, DEC_PC_4, r.pc4);
                chk({tag, "_imm"}, DEC_IMM,  r.imm);
            end
        end
    endtask

    task automatic ctl(input string tag, input logic exp_pcw);
        #1;
        chk({tag, "_pcw"}, {31'd0, PC_WRITE},   {31'd0, exp_pcw});
        chk({tag, "_bub"}, {31'd0, DEC_BUBBLE}, {31'd0, ~exp_pcw});
    endtask

    logic hz_pcw;

    initial begin
`ifdef DECODE_LOAD_USE_EN
        hz_pcw = 1'b0;
`else
        hz_pcw = 1'b1;
`endif
        #12;
        chk("rst_valid", {31'd0, DEC_VALID}, 32'd0);
        chk("rst_ir", DEC_IR, 32'd0);
        chk("rst_imm", DEC_IMM, 32'd0);
        chk("rst_pcw", {31'd0, PC_WRITE}, 32'd1);
        chk("rst_bub", {31'd0, DEC_BUBBLE}, 32'd0);
        @(negedge CLOCK);
        RESET = 1'b1;

        // warmup discards two words, third is real
        cyc(ADDI5, 32'd5, 1'b0, 1'b0, "wu0");
        cyc(ADDI5, 32'd5, 1'b0, 1'b0, "wu1");
        cyc(ADDI5, 32'd5, 1'b1, 1'b1, "wu2");
        chk("wu2_rd", {27'd0, DEC_RD_ADDR}, 32'd1);
        chk("wu2_op", {25'd0, DEC_OPCODE}, 32'h13);

        cyc(BEQM4, 32'hFFFFFFFC, 1'b1, 1'b1, "beq");
        chk("beq_op", {25'd0, DEC_OPCODE}, 32'h63);
        cyc(ADDIM1, 32'hFFFFFFFF, 1'b1, 1'b1, "addim1");
        cyc(SWM4, 32'hFFFFFFFC, 1'b1, 1'b1, "swm4");
        cyc(JAL8, 32'd8, 1'b1, 1'b1, "jal8");
        cyc(JALM8, 32'hFFFFFFF8, 1'b1, 1'b1, "jalm8");
        cyc(FENCEX, 32'd0, 1'b1, 1'b1, "other");

        // load-use on rs2 of add x3,x1,x2
        cyc(ADD312, 32'd0, 1'b1, 1'b1, "add");
        chk("add_rd", {27'd0, DEC_RD_ADDR}, 32'd3);
        EX_MEM_READ = 1'b1;
        EX_RD_ADDR  = 5'd2;
        FETCH_IR    = ADDI5;
        FETCH_PC    = pc;
        FETCH_PC_4  = pc + 32'd4;
        ctl("haz", hz_pcw);
`ifdef DECODE_LOAD_USE_EN
        @(posedge CLOCK);
        #1;
        chk("stall_ir", DEC_IR, ADD312);
        chk("stall_valid", {31'd0, DEC_VALID}, 32'd1);
        ctl("stall", 1'b1);
`endif
        cyc(ADDI5, 32'd5, 1'b1, 1'b1, "post_stall");
        ctl("post_stall", 1'b1);
        EX_RD_ADDR = 5'd5;
        ctl("rs2_unused", 1'b1);
        EX_MEM_READ = 1'b0;

        cyc(LUI28, 32'h00028000, 1'b1, 1'b1, "lui");
        EX_MEM_READ = 1'b1;
        EX_RD_ADDR  = 5'd5;
        ctl("lui_rs1_unused", 1'b1);
        EX_MEM_READ = 1'b0;

        cyc(ADD312, 32'd0, 1'b1, 1'b1, "add2");
        EX_MEM_READ = 1'b1;
        EX_RD_ADDR  = 5'd0;
        ctl("rd_x0", 1'b1);
        EX_RD_ADDR = 5'd1;
        ctl("rs1_hit", hz_pcw);
        EX_MEM_READ = 1'b0;
        ctl("no_load", 1'b1);
        EX_RD_ADDR = 5'd0;

        cyc(SW8, 32'd8, 1'b1, 1'b1, "sw8");
        chk("sw8_rs1", {27'd0, DEC_RS1_ADDR}, 32'd1);
        chk("sw8_rs2", {27'd0, DEC_RS2_ADDR}, 32'd2);
        EX_MEM_READ = 1'b1;
        EX_RD_ADDR  = 5'd2;
        ctl("sw_rs2_hit", hz_pcw);
        EX_MEM_READ = 1'b0;
        EX_RD_ADDR  = 5'd0;

        // flush coincident with a load-use hazard
        cyc(ADD312, 32'd0, 1'b1, 1'b1, "add3");
        EX_MEM_READ = 1'b1;
        EX_RD_ADDR  = 5'd2;
        FLUSH       = 1'b1;
        ctl("flush_haz", 1'b1);
        cyc(JUNK, 32'd0, 1'b0, 1'b0, "fl0");
        FLUSH       = 1'b0;
        EX_MEM_READ = 1'b0;
        EX_RD_ADDR  = 5'd0;
        cyc(JUNK, 32'd0, 1'b0, 1'b0, "fl1");
        cyc(JUNK, 32'd0, 1'b0, 1'b0, "fl2");
        cyc(ADDI5, 32'd5, 1'b1, 1'b1, "fl3");

        // second flush while squashing restarts the count
        FLUSH = 1'b1;
        cyc(JUNK, 32'd0, 1'b0, 1'b0, "df0");
        FLUSH = 1'b0;
        cyc(JUNK, 32'd0, 1'b0, 1'b0, "df1");
        FLUSH = 1'b1;
        cyc(JUNK, 32'd0, 1'b0, 1'b0, "df2");
        FLUSH = 1'b0;
        cyc(JUNK, 32'd0, 1'b0, 1'b0, "df3");
        cyc(JUNK, 32'd0, 1'b0, 1'b0, "df4");
        cyc(ADDIM1, 32'hFFFFFFFF, 1'b1, 1'b1, "df5");

        // asynchronous reset mid-squash
        FLUSH = 1'b1;
        cyc(JAL8, 32'd8, 1'b0, 1'b0, "rs0");
        FLUSH       = 1'b0;
        EX_MEM_READ = 1'b1;
        EX_RD_ADDR  = 5'd1;
        #2;
        RESET = 1'b0;
        #1;
        chk("arst_valid", {31'd0, DEC_VALID}, 32'd0);
        chk("arst_ir", DEC_IR, 32'd0);
        chk("arst_pc", DEC_PC, 32'd0);
        chk("arst_pc4", DEC_PC_4, 32'd0);
        chk("arst_imm", DEC_IMM, 32'd0);
        chk("arst_rd", {27'd0, DEC_RD_ADDR}, 32'd0);
        chk("arst_pcw", {31'd0, PC_WRITE}, 32'd1);
        chk("arst_bub", {31'd0, DEC_BUBBLE}, 32'd0);
        @(negedge CLOCK);
        RESET       = 1'b1;
        EX_MEM_READ = 1'b0;
        EX_RD_ADDR  = 5'd0;

        // flush during warmup has no effect
        FLUSH = 1'b1;
        cyc(JUNK, 32'd0, 1'b0, 1'b0, "rw0");
        FLUSH = 1'b0;
        cyc(JUNK, 32'd0, 1'b0, 1'b0, "rw1");
        cyc(ADD312, 32'd0, 1'b1, 1'b1, "rw2");

        chk("sb_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
